// File: rtl/peb_psum_bank_ctrl.sv
// Psum SRAM distributor for one PE block: private banks per PEC, ping/pong pair for the last PEC
// with a handshaked frame swap to the pooling unit. Optional macro PEB_PSUM_CLR_EN zeroes words as pool reads them.
module peb_psum_bank_ctrl #(
    parameter int NUM_PEC    = 3,
    parameter int PSUM_WIDTH = 23,
    parameter int LENPSUM    = 16,
    localparam int AW = $clog2(LENPSUM),
    localparam int BW = PSUM_WIDTH * LENPSUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CTRLPEB_FrtBlk,
    input  logic                  CTRLPEB_FnhFrm,
    input  logic [NUM_PEC-1:0]    PECRAM_EnWr,
    input  logic [NUM_PEC*AW-1:0] PECRAM_AddrWr,
    input  logic [NUM_PEC*BW-1:0] PECRAM_DatWr,
    input  logic [NUM_PEC-1:0]    PECRAM_EnRd,
    input  logic [NUM_PEC*AW-1:0] PECRAM_AddrRd,
    output logic [NUM_PEC*BW-1:0] RAMPEC_DatRd,
    output logic                  PEB_Stall,
    output logic                  PEB_ErrWrDrop,
    input  logic                  POOLPEB_EnRd,
    input  logic [AW-1:0]         POOLPEB_AddrRd,
    output logic [BW-1:0]         PEBPOOL_Dat,
    output logic                  PEBPOOL_ValDat,
    output logic                  PEBPOOL_RdyFrm,
    input  logic                  POOLPEB_FnhRd
);

    localparam int LAST = NUM_PEC - 1;
    localparam int NB   = NUM_PEC + 1;
    localparam int PING = NUM_PEC - 1;
    localparam int PONG = NUM_PEC;

    typedef enum logic {S_FILL, S_WAIT} state_t;

    state_t        r_state;
    logic          r_wrSel;
    logic          r_poolBusy;
    logic          r_stall;
    logic          r_errWrDrop;
    logic          r_frtBlkD;
    logic          r_wrSelD;
    logic          r_valDat;

    logic [BW-1:0] r_mem   [NB][LENPSUM];
    logic [BW-1:0] r_bankQ [NB];

    logic          w_bWrEn   [NB];
    logic [AW-1:0] w_bWrAddr [NB];
    logic [BW-1:0] w_bWrDat  [NB];
    logic          w_bRdEn   [NB];
    logic [AW-1:0] w_bRdAddr [NB];

    logic          w_poolAcc;
    logic          w_lastWr;
    logic          w_lastRdEn;
    logic [AW-1:0] w_lastWrAddr;
    logic [BW-1:0] w_lastWrDat;
    logic [AW-1:0] w_lastRdAddr;
    logic [BW-1:0] w_lastOwnQ;

    assign w_poolAcc    = POOLPEB_EnRd & r_poolBusy;
    assign w_lastWr     = PECRAM_EnWr[LAST] & (r_state != S_WAIT);
    assign w_lastRdEn   = PECRAM_EnRd[LAST] & ~CTRLPEB_FrtBlk;
    assign w_lastWrAddr = PECRAM_AddrWr[LAST*AW +: AW];
    assign w_lastWrDat  = PECRAM_DatWr[LAST*BW +: BW];
    assign w_lastRdAddr = PECRAM_AddrRd[LAST*AW +: AW];

    // Bank port routing; ping/pong ports are split between the last PEC and the pool by WrSel.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            w_bWrEn[b]   = 1'b0;
            w_bWrAddr[b] = '0;
            w_bWrDat[b]  = '0;
            w_bRdEn[b]   = 1'b0;
            w_bRdAddr[b] = '0;
        end
        for (int i = 0; i < LAST; i++) begin
            w_bWrEn[i]   = PECRAM_EnWr[i];
            w_bWrAddr[i] = PECRAM_AddrWr[i*AW +: AW];
            w_bWrDat[i]  = PECRAM_DatWr[i*BW +: BW];
            w_bRdEn[i]   = PECRAM_EnRd[i];
            w_bRdAddr[i] = PECRAM_AddrRd[i*AW +: AW];
        end
        w_bRdEn[PING]   = r_wrSel ? w_poolAcc      : w_lastRdEn;
        w_bRdAddr[PING] = r_wrSel ? POOLPEB_AddrRd : w_lastRdAddr;
        w_bRdEn[PONG]   = r_wrSel ? w_lastRdEn     : w_poolAcc;
        w_bRdAddr[PONG] = r_wrSel ? w_lastRdAddr   : POOLPEB_AddrRd;
`ifdef PEB_PSUM_CLR_EN
        w_bWrEn[PING]   = r_wrSel ? w_poolAcc      : w_lastWr;
        w_bWrAddr[PING] = r_wrSel ? POOLPEB_AddrRd : w_lastWrAddr;
        w_bWrDat[PING]  = r_wrSel ? '0             : w_lastWrDat;
        w_bWrEn[PONG]   = r_wrSel ? w_lastWr       : w_poolAcc;
        w_bWrAddr[PONG] = r_wrSel ? w_lastWrAddr   : POOLPEB_AddrRd;
        w_bWrDat[PONG]  = r_wrSel ? w_lastWrDat    : '0;
`else
        w_bWrEn[PING]   = w_lastWr & ~r_wrSel;
        w_bWrAddr[PING] = w_lastWrAddr;
        w_bWrDat[PING]  = w_lastWrDat;
        w_bWrEn[PONG]   = w_lastWr & r_wrSel;
        w_bWrAddr[PONG] = w_lastWrAddr;
        w_bWrDat[PONG]  = w_lastWrDat;
`endif
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (w_bWrEn[b])
                r_mem[b][w_bWrAddr[b]] <= w_bWrDat[b];
            if (w_bRdEn[b])
                r_bankQ[b] <= r_mem[b][w_bRdAddr[b]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_wrSel     <= 1'b0;
            r_poolBusy  <= 1'b0;
            r_stall     <= 1'b0;
            r_errWrDrop <= 1'b0;
        end else begin
            if ((r_state == S_WAIT) && PECRAM_EnWr[LAST])
                r_errWrDrop <= 1'b1;
            case (r_state)
                S_FILL: begin
                    if (CTRLPEB_FnhFrm) begin
                        if (!r_poolBusy || POOLPEB_FnhRd) begin
                            r_wrSel    <= ~r_wrSel;
                            r_poolBusy <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_stall <= 1'b1;
                        end
                    end else if (POOLPEB_FnhRd) begin
                        r_poolBusy <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (POOLPEB_FnhRd) begin
                        r_wrSel    <= ~r_wrSel;
                        r_poolBusy <= 1'b1;
                        r_state    <= S_FILL;
                        r_stall    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    // Mux selects delayed one cycle so they line up with the SRAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frtBlkD <= 1'b0;
            r_wrSelD  <= 1'b0;
            r_valDat  <= 1'b0;
        end else begin
            r_frtBlkD <= CTRLPEB_FrtBlk;
            r_wrSelD  <= r_wrSel;
            r_valDat  <= w_poolAcc;
        end
    end

    assign w_lastOwnQ = r_wrSelD ? r_bankQ[PONG] : r_bankQ[PING];

    always_comb begin
        RAMPEC_DatRd = '0;
        RAMPEC_DatRd[0 +: BW] = r_frtBlkD ? '0 : r_bankQ[0];
        for (int i = 1; i < LAST; i++)
            RAMPEC_DatRd[i*BW +: BW] = r_frtBlkD ? r_bankQ[i-1] : r_bankQ[i];
        RAMPEC_DatRd[LAST*BW +: BW] = r_frtBlkD ? r_bankQ[LAST-1] : w_lastOwnQ;
    end

    assign PEBPOOL_Dat    = r_wrSelD ? r_bankQ[PING] : r_bankQ[PONG];
    assign PEBPOOL_ValDat = r_valDat;
    assign PEBPOOL_RdyFrm = r_poolBusy;
    assign PEB_Stall      = r_stall;
    assign PEB_ErrWrDrop  = r_errWrDrop;

endmodule

// File: tb/tb_peb_psum_bank_ctrl.sv
// Self-checking bench for peb_psum_bank_ctrl (NUM_PEC=5, LENPSUM=32) against a frame-ownership
// reference model; follows PEB_PSUM_CLR_EN when it is defined for the build.
module tb_peb_psum_bank_ctrl;

    localparam int NP  = 5;
    localparam int LEN = 32;
    localparam int PW  = 23;
    localparam int AW  = $clog2(LEN);
    localparam int BW  = PW * LEN;
    localparam int L   = NP - 1;
    localparam int NB  = NP + 1;

    logic             clk;
    logic             rst_n;
    logic             frtBlk;
    logic             fnhFrm;
    logic [NP-1:0]    enWr;
    logic [NP*AW-1:0] addrWr;
    logic [NP*BW-1:0] datWr;
    logic [NP-1:0]    enRd;
    logic [NP*AW-1:0] addrRd;
    logic [NP*BW-1:0] datRd;
    logic             stall;
    logic             errDrop;
    logic             poolEnRd;
    logic [AW-1:0]    poolAddr;
    logic [BW-1:0]    poolDat;
    logic             valDat;
    logic             rdyFrm;
    logic             fnhRd;

    logic [BW-1:0] mMem [NB][LEN];
    int            mWrBank;
    logic          mPoolBusy;
    logic          mStalled;
    logic          mErr;
    logic [BW-1:0] eRd [NP];
    logic          eRdVal [NP];
    logic [BW-1:0] ePool;
    logic          eVal;

    int checkCount;
    int passCount;
    int failCount;

    peb_psum_bank_ctrl #(
        .NUM_PEC(NP),
        .PSUM_WIDTH(PW),
        .LENPSUM(LEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .CTRLPEB_FrtBlk(frtBlk),
        .CTRLPEB_FnhFrm(fnhFrm),
        .PECRAM_EnWr(enWr),
        .PECRAM_AddrWr(addrWr),
        .PECRAM_DatWr(datWr),
        .PECRAM_EnRd(enRd),
        .PECRAM_AddrRd(addrRd),
        .RAMPEC_DatRd(datRd),
        .PEB_Stall(stall),
        .PEB_ErrWrDrop(errDrop),
        .POOLPEB_EnRd(poolEnRd),
        .POOLPEB_AddrRd(poolAddr),
        .PEBPOOL_Dat(poolDat),
        .PEBPOOL_ValDat(valDat),
        .PEBPOOL_RdyFrm(rdyFrm),
        .POOLPEB_FnhRd(fnhRd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] randWord();
        logic [BW-1:0] w;
        w = '0;
        for (int k = 0; k < (BW + 31) / 32; k++)
            w = (w << 32) | BW'($urandom);
        return w;
    endfunction

    function automatic int rdAddr(int i);
        return int'(addrRd[i*AW +: AW]);
    endfunction

    function automatic int wrAddr(int i);
        return int'(addrWr[i*AW +: AW]);
    endfunction

    task automatic clearInputs();
        frtBlk   = 1'b0;
        fnhFrm   = 1'b0;
        fnhRd    = 1'b0;
        enWr     = '0;
        addrWr   = '0;
        datWr    = '0;
        enRd     = '0;
        addrRd   = '0;
        poolEnRd = 1'b0;
        poolAddr = '0;
    endtask

    task automatic setWr(int i, int a, logic [BW-1:0] d);
        enWr[i]              = 1'b1;
        addrWr[i*AW +: AW]   = AW'(a);
        datWr[i*BW +: BW]    = d;
    endtask

    task automatic setRd(int i, int a);
        enRd[i]            = 1'b1;
        addrRd[i*AW +: AW] = AW'(a);
    endtask

    task automatic modelReset();
        mWrBank   = L;
        mPoolBusy = 1'b0;
        mStalled  = 1'b0;
        mErr      = 1'b0;
        eVal      = 1'b0;
        for (int i = 0; i < NP; i++) eRdVal[i] = 1'b0;
    endtask

    // Predict the next cycle from the current inputs, then clock once and settle.
    task automatic applyStimulus();
        int pb;
        pb = (mWrBank == L) ? L + 1 : L;
        for (int i = 0; i < NP; i++) eRdVal[i] = 1'b0;
        if (frtBlk) begin
            eRd[0]    = '0;
            eRdVal[0] = 1'b1;
            for (int i = 1; i < NP; i++)
                if (enRd[i-1]) begin
                    eRd[i]    = mMem[i-1][rdAddr(i-1)];
                    eRdVal[i] = 1'b1;
                end
        end else begin
            for (int i = 0; i < L; i++)
                if (enRd[i]) begin
                    eRd[i]    = mMem[i][rdAddr(i)];
                    eRdVal[i] = 1'b1;
                end
            if (enRd[L]) begin
                eRd[L]    = mMem[mWrBank][rdAddr(L)];
                eRdVal[L] = 1'b1;
            end
        end
        eVal = poolEnRd && mPoolBusy;
        if (eVal) ePool = mMem[pb][int'(poolAddr)];
        for (int i = 0; i < L; i++)
            if (enWr[i]) mMem[i][wrAddr(i)] = datWr[i*BW +: BW];
        if (enWr[L]) begin
            if (mStalled) mErr = 1'b1;
            else          mMem[mWrBank][wrAddr(L)] = datWr[L*BW +: BW];
        end
`ifdef PEB_PSUM_CLR_EN
        if (eVal) mMem[pb][int'(poolAddr)] = '0;
`endif
        if (mStalled) begin
            if (fnhRd) begin
                mWrBank   = pb;
                mPoolBusy = 1'b1;
                mStalled  = 1'b0;
            end
        end else if (fnhFrm) begin
            if (!mPoolBusy || fnhRd) begin
                mWrBank   = pb;
                mPoolBusy = 1'b1;
            end else begin
                mStalled = 1'b1;
            end
        end else if (fnhRd) begin
            mPoolBusy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string tag, logic [BW-1:0] obs, logic [BW-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(string step);
        for (int i = 0; i < NP; i++)
            if (eRdVal[i])
                checkOutput($sformatf("%s rd%0d", step, i), datRd[i*BW +: BW], eRd[i]);
        checkOutput({step, " stall"},  BW'(stall),   BW'(mStalled));
        checkOutput({step, " rdyFrm"}, BW'(rdyFrm),  BW'(mPoolBusy));
        checkOutput({step, " errDrop"}, BW'(errDrop), BW'(mErr));
        checkOutput({step, " valDat"}, BW'(valDat),  BW'(eVal));
        if (eVal) checkOutput({step, " poolDat"}, poolDat, ePool);
    endtask

    initial begin
        logic [BW-1:0] p55;
        logic [BW-1:0] pAA;
        logic [BW-1:0] tmp;
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        p55 = {(BW/8){8'h55}};
        pAA = {(BW/8){8'hAA}};

        rst_n = 1'b0;
        clearInputs();
        modelReset();
        #12;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] filling private banks and ping bank");
        for (int a = 0; a < LEN; a++) begin
            clearInputs();
            for (int i = 0; i < NP; i++) setWr(i, a, randWord());
            applyStimulus();
            checkAll("fill");
        end
        clearInputs();
        setWr(0, 3, p55);
        setWr(1, 3, pAA);
        applyStimulus();

        $display("[TB] shift mode");
        clearInputs();
        frtBlk = 1'b1;
        for (int i = 0; i < NP; i++) setRd(i, 3);
        applyStimulus();
        checkAll("shift");
        clearInputs();
        setRd(1, 3);
        applyStimulus();
        checkAll("shiftFall");

        for (int c = 0; c < 20; c++) begin
            clearInputs();
            frtBlk = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NP; i++)
                if ($urandom_range(0, 1) == 1) setRd(i, $urandom_range(0, LEN - 1));
            applyStimulus();
            checkAll("rdMix");
        end

        $display("[TB] pool handshake");
        clearInputs();
        poolEnRd = 1'b1;
        poolAddr = AW'(5);
        applyStimulus();
        checkAll("poolIdle");
        clearInputs();
        setWr(L, 5, BW'(7));
        applyStimulus();
        clearInputs();
        fnhFrm = 1'b1;
        applyStimulus();
        checkAll("frame1");
        clearInputs();
        poolEnRd = 1'b1;
        poolAddr = AW'(5);
        applyStimulus();
        checkAll("pool5");

        for (int a = 0; a < LEN; a++) begin
            clearInputs();
            setWr(L, a, randWord());
            if (a > 0) setRd(L, a - 1);
            poolEnRd = 1'b1;
            poolAddr = AW'($urandom_range(0, LEN - 1));
            applyStimulus();
            checkAll("fill2");
        end

        clearInputs();
        fnhFrm = 1'b1;
        applyStimulus();
        checkAll("enterWait");
        clearInputs();
        tmp = randWord();
        setWr(L, 6, tmp);
        setRd(L, 6);
        applyStimulus();
        checkAll("dropWr");
        clearInputs();
        setRd(L, 6);
        fnhFrm = 1'b1;
        applyStimulus();
        checkAll("waitFnhFrm");
        clearInputs();
        fnhRd = 1'b1;
        applyStimulus();
        checkAll("leaveWait");
        for (int c = 0; c < 4; c++) begin
            clearInputs();
            poolEnRd = 1'b1;
            poolAddr = AW'($urandom_range(0, LEN - 1));
            applyStimulus();
            checkAll("pool2");
        end

        clearInputs();
        fnhFrm = 1'b1;
        fnhRd  = 1'b1;
        applyStimulus();
        checkAll("sameCycle");
        clearInputs();
        applyStimulus();
        checkAll("sameCycleNext");
        clearInputs();
        fnhRd = 1'b1;
        applyStimulus();
        checkAll("poolDone");
        clearInputs();
        poolEnRd = 1'b1;
        applyStimulus();
        checkAll("poolIgnored");

        $display("[TB] randomized traffic");
        for (int c = 0; c < 60; c++) begin
            clearInputs();
            frtBlk = ($urandom_range(0, 3) == 0);
            fnhFrm = ($urandom_range(0, 5) == 0);
            fnhRd  = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 1) == 1) setWr(i, $urandom_range(0, LEN - 1), randWord());
                if ($urandom_range(0, 1) == 1) setRd(i, $urandom_range(0, LEN - 1));
            end
            poolEnRd = ($urandom_range(0, 1) == 1);
            poolAddr = AW'($urandom_range(0, LEN - 1));
            applyStimulus();
            checkAll("rand");
        end

        $display("[TB] async reset while waiting");
        clearInputs();
        fnhFrm = 1'b1;
        applyStimulus();
        clearInputs();
        fnhFrm = 1'b1;
        applyStimulus();
        checkAll("preReset");
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("asyncReset");
        #2;
        rst_n = 1'b1;
        clearInputs();
        tmp = randWord();
        setWr(L, 9, tmp);
        applyStimulus();
        checkAll("postReset");
        clearInputs();
        fnhFrm = 1'b1;
        applyStimulus();
        checkAll("postResetFrm");
        clearInputs();
        poolEnRd = 1'b1;
        poolAddr = AW'(9);
        applyStimulus();
        checkAll("postResetPool");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/peb_psum_bank_ctrl.md
Name: peb_psum_bank_ctrl

Overview:
- Parametrised psum-SRAM distributor for one PE block of NUM_PEC cascaded PECs. It supersedes the fixed 3-PEC wiring.
- Owns NUM_PEC+1 SRAM_DUAL banks:
  - banks 0..NUM_PEC-2 are private to PEC0..PEC(NUM_PEC-2);
  - banks NUM_PEC-1 and NUM_PEC are a ping/pong pair for the last PEC.
- Adds a handshaked frame swap with the pooling unit, replacing the blind toggle. Read-data muxing is aligned to SRAM read latency.

Parameters:
- NUM_PEC, 3, PECs in the cascade; must be >= 2.
- PSUM_WIDTH, 23, bits per psum.
- LENPSUM, 16, psums per SRAM word and words per bank.
- AW, clog2(LENPSUM), address width (derived; not overridden).
- BW, PSUM_WIDTH*LENPSUM, bank word width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- CTRLPEB_FrtBlk  in  1  first block of a new frame is in progress
- CTRLPEB_FnhFrm  in  1  one-cycle pulse: last PEC finished the frame
- PECRAM_EnWr  in  NUM_PEC  per-PEC write enable
- PECRAM_AddrWr  in  NUM_PEC*AW  per-PEC write address; PEC i at [i*AW +: AW]
- PECRAM_DatWr  in  NUM_PEC*BW  per-PEC write data
- PECRAM_EnRd  in  NUM_PEC  per-PEC read enable
- PECRAM_AddrRd  in  NUM_PEC*AW  per-PEC read address
- RAMPEC_DatRd  out  NUM_PEC*BW  per-PEC read data, 1 cycle after EnRd
- PEB_Stall  out  1  frame swap blocked; upstream must hold the last PEC
- PEB_ErrWrDrop  out  1  sticky: a last-PEC write was dropped during stall
- POOLPEB_EnRd  in  1  pool read enable
- POOLPEB_AddrRd  in  AW  pool read address
- PEBPOOL_Dat  out  BW  pool read data
- PEBPOOL_ValDat  out  1  PEBPOOL_Dat valid; 1 cycle after an accepted pool read
- PEBPOOL_RdyFrm  out  1  a completed frame bank is owned by pool
- POOLPEB_FnhRd  in  1  one-cycle pulse: pool finished with its bank

Behaviour:
- Banks are SRAM_DUAL with 1-cycle read latency. Every read-data mux select is the control registered one cycle (FrtBlk_d, WrSel_d, and so on).
- Private path, i < NUM_PEC-1:
  - bank i write port is always PEC i;
  - read port is PEC i addr/en.
- Normal mode, FrtBlk=0: RAMPEC_DatRd[i] = bank i data.
- FrtBlk=1, shift mode:
  - RAMPEC_DatRd[0] = 0;
  - RAMPEC_DatRd[i] = bank i-1 data for 1 <= i <= NUM_PEC-1, where bank i-1 is read at PEC i-1's address/enable.
  - Last PEC's own bank read enable is gated to 0 during FrtBlk.
  - Data select uses FrtBlk_d, so the first word after FrtBlk falls is never X.
- Ping/pong state:
  - WrSel: bank written by the last PEC; 0 selects NUM_PEC-1, 1 selects NUM_PEC.
  - PoolBusy: the other bank holds an unread frame.
- Pool reads go to the non-WrSel bank and are accepted only when PoolBusy=1. When PoolBusy=0 they are ignored and ValDat stays 0.
- FSM states:
  - FILL: on FnhFrm with (PoolBusy=0 or FnhRd in the same cycle), toggle WrSel, set PoolBusy=1, stay in FILL.
  - FILL: on FnhFrm with PoolBusy=1 and no FnhRd, go to WAIT.
  - WAIT: PEB_Stall=1. On FnhRd, toggle WrSel, set PoolBusy=1, go to FILL; the swap happens in the FnhRd cycle and Stall drops the next cycle.
- In WAIT, last-PEC writes are dropped and set PEB_ErrWrDrop; last-PEC reads still go to WrSel.
- FnhRd in FILL with no FnhFrm clears PoolBusy.
- FnhFrm while already in WAIT is ignored.
- PEBPOOL_RdyFrm = PoolBusy.
- Reset values:
  - WrSel=0, PoolBusy=0, state FILL, all _d registers 0;
  - Stall=0, ErrWrDrop=0, RdyFrm=0, ValDat=0;
  - RAMPEC_DatRd/PEBPOOL_Dat show registered-select mux outputs (data is don't-care until first read).
- Reset mid-frame discards ownership state. Bank contents are not cleared.

Optional Feature:
- Macro PEB_PSUM_CLR_EN.
- When defined: each accepted pool read also writes all-zero at the same address of the pool-owned bank in the same cycle (that bank's write port is otherwise idle), so the bank is clean when it next becomes WrSel.
- When undefined: the pool-owned bank's write port is tied off, and the last PEC must overwrite every word itself.

Test Plan:
- FrtBlk=1, bank0[3]=0x55…, PEC0 EnRd addr 3 -> next cycle RAMPEC_DatRd[1]=0x55…, RAMPEC_DatRd[0]=0; FrtBlk falls, PEC1 reads bank1[3]=0xAA… -> 0xAA…, no X.
- From reset, last PEC writes bank NUM_PEC-1[5]=7, FnhFrm -> WrSel=1, RdyFrm=1; pool reads addr 5 -> next cycle Dat=7, ValDat=1.
- Second FnhFrm with PoolBusy=1 -> Stall=1 next cycle; last-PEC write during stall -> ErrWrDrop=1, bank unchanged; FnhRd -> WrSel toggles, Stall=0 next cycle.
- FnhFrm and FnhRd in the same cycle with PoolBusy=1 -> immediate swap, Stall never asserts.
- Pool read with RdyFrm=0 -> ValDat=0, no clear write; with PEB_PSUM_CLR_EN, reading addr 5 twice across a frame -> second read returns 0.
- NUM_PEC=5, LENPSUM=32: full cascade shift check for all i, plus async reset in WAIT -> state FILL, Stall=0, WrSel=0.
